vending_multi: RTL and testbench

Parametrised multi-product vending controller, successor to the fixed 3-product vending block.
- Sequential price-load phase on one data port, then credit accumulation, selection, refund and change.
- New versus the previous generation: per-product stock counters, restocking, saturating credit with coin reject, and explicit error reporting.
- Sits between the coin/keypad front end and the dispenser/change-payout logic.

---
 rtl/vending_pkg.sv | 21 ++
 rtl/vend_credit_acc.sv | 32 +++
 rtl/vending_multi.sv | 215 +++++++++++++++++++++
 tb/tb_vending_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and default widths for the multi-product vending controller.
package vending_pkg;

   typedef enum logic {
      LOAD   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_FUNDS   = 2'd1,
      ERR_SOLDOUT = 2'd2,
      ERR_BADSEL  = 2'd3
   } err_t;

   localparam int DEF_NUM_PROD = 4;
   localparam int DEF_PRICE_W  = 8;
   localparam int DEF_CREDIT_W = 10;
   localparam int DEF_STOCK_W  = 4;

endpackage

// File: rtl/vend_credit_acc.sv
// Saturating coin adder: adds an inserted coin to the credit unless the sum
// would overflow, in which case the coin is rejected and credit passes through.
module vend_credit_acc
   import vending_pkg::*;
#(
   parameter int PRICE_W  = DEF_PRICE_W,
   parameter int CREDIT_W = DEF_CREDIT_W
) (
   input  logic [CREDIT_W-1:0] credit_i,
   input  logic                coin_valid_i,
   input  logic [PRICE_W-1:0]  coin_in_i,
   output logic [CREDIT_W-1:0] eff_o,
   output logic                rej_o
);

   logic [CREDIT_W:0] sum;

   // One extra bit catches overflow past the top of the credit range
   always_comb begin
      sum   = {1'b0, credit_i} + {{(CREDIT_W + 1 - PRICE_W){1'b0}}, coin_in_i};
      eff_o = credit_i;
      rej_o = 1'b0;
      if (coin_valid_i) begin
         if (sum[CREDIT_W]) begin
            rej_o = 1'b1;
         end else begin
            eff_o = sum[CREDIT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/vending_multi.sv
// Multi-product vending controller: sequential price load, then credit,
// selection, refund, change, per-product stock with restocking, error codes.
module vending_multi
   import vending_pkg::*;
#(
   parameter int NUM_PROD = DEF_NUM_PROD,
   parameter int PRICE_W  = DEF_PRICE_W,
   parameter int CREDIT_W = DEF_CREDIT_W,
   parameter int STOCK_W  = DEF_STOCK_W,
   localparam int SEL_W   = $clog2(NUM_PROD)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                price_valid,
   input  logic [PRICE_W-1:0]  price_in,
   input  logic                restock_valid,
   input  logic [SEL_W-1:0]    restock_idx,
   input  logic [STOCK_W-1:0]  restock_qty,
   input  logic                coin_valid,
   input  logic [PRICE_W-1:0]  coin_in,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel_idx,
   input  logic                refund,
   output logic                ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                vend_valid,
   output logic [SEL_W-1:0]    vend_idx,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic                coin_rej,
   output logic                err_valid,
   output logic [1:0]          err_code
);

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     ptr_q, ptr_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic [PRICE_W-1:0]   price_q [NUM_PROD];
   logic [PRICE_W-1:0]   price_d [NUM_PROD];
   logic [STOCK_W-1:0]   stock_q [NUM_PROD];
   logic [STOCK_W-1:0]   stock_d [NUM_PROD];

   logic                 vendValid_q, vendValid_d;
   logic [SEL_W-1:0]     vendIdx_q, vendIdx_d;
   logic                 changeValid_q, changeValid_d;
   logic [CREDIT_W-1:0]  changeAmt_q, changeAmt_d;
   logic                 coinRej_q, coinRej_d;
   logic                 errValid_q, errValid_d;
   err_t                 errCode_q, errCode_d;

   logic [CREDIT_W-1:0]  eff;
   logic                 accRej;
   logic                 selInRange;
   logic [PRICE_W-1:0]   selPrice;
   logic [STOCK_W-1:0]   selStock;
   logic                 doVend;
   logic [STOCK_W-1:0]   stockBase;
   logic [STOCK_W:0]     stockSum;

   vend_credit_acc #(
      .PRICE_W  (PRICE_W),
      .CREDIT_W (CREDIT_W)
   ) u_acc (
      .credit_i     (credit_q),
      .coin_valid_i (coin_valid),
      .coin_in_i    (coin_in),
      .eff_o        (eff),
      .rej_o        (accRej)
   );

   // Decoded lookup so out-of-range selections never index past the arrays
   always_comb begin
      selInRange = 1'b0;
      selPrice   = '0;
      selStock   = '0;
      for (int i = 0; i < NUM_PROD; i++) begin
         if (sel_idx == SEL_W'(i)) begin
            selInRange = 1'b1;
            selPrice   = price_q[i];
            selStock   = stock_q[i];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      credit_d      = credit_q;
      price_d       = price_q;
      stock_d       = stock_q;
      vendValid_d   = 1'b0;
      vendIdx_d     = '0;
      changeValid_d = 1'b0;
      changeAmt_d   = '0;
      coinRej_d     = 1'b0;
      errValid_d    = 1'b0;
      errCode_d     = ERR_NONE;
      doVend        = 1'b0;
      stockBase     = '0;
      stockSum      = '0;

      case (state_q)
         LOAD: begin
            coinRej_d = coin_valid;
            if (sel_valid) begin
               errValid_d = 1'b1;
               errCode_d  = ERR_BADSEL;
            end
            if (price_valid) begin
               for (int i = 0; i < NUM_PROD; i++) begin
                  if (ptr_q == SEL_W'(i)) begin
                     price_d[i] = price_in;
                  end
               end
               if (ptr_q == SEL_W'(NUM_PROD - 1)) begin
                  ptr_d   = '0;
                  state_d = ACTIVE;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end

         ACTIVE: begin
            coinRej_d = accRej;
            credit_d  = eff;
            if (refund) begin
               changeValid_d = 1'b1;
               changeAmt_d   = eff;
               credit_d      = '0;
            end else if (sel_valid) begin
               if (!selInRange) begin
                  errValid_d = 1'b1;
                  errCode_d  = ERR_BADSEL;
               end else if (selStock == '0) begin
                  errValid_d = 1'b1;
                  errCode_d  = ERR_SOLDOUT;
               end else if (eff < CREDIT_W'(selPrice)) begin
                  errValid_d = 1'b1;
                  errCode_d  = ERR_FUNDS;
               end else begin
                  doVend        = 1'b1;
                  vendValid_d   = 1'b1;
                  vendIdx_d     = sel_idx;
                  changeValid_d = 1'b1;
                  changeAmt_d   = eff - CREDIT_W'(selPrice);
                  credit_d      = '0;
               end
            end

            // Vend decrement first, then saturating restock on the result
            for (int i = 0; i < NUM_PROD; i++) begin
               stockBase = stock_q[i];
               if (doVend && (sel_idx == SEL_W'(i))) begin
                  stockBase = stockBase - 1'b1;
               end
               if (restock_valid && (restock_idx == SEL_W'(i))) begin
                  stockSum   = {1'b0, stockBase} + {1'b0, restock_qty};
                  stock_d[i] = stockSum[STOCK_W] ? '1 : stockSum[STOCK_W-1:0];
               end else begin
                  stock_d[i] = stockBase;
               end
            end
         end

         default: state_d = LOAD;
      endcase
   end

   // Reset discards any pending credit without paying it out
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= LOAD;
         ptr_q         <= '0;
         credit_q      <= '0;
         vendValid_q   <= 1'b0;
         vendIdx_q     <= '0;
         changeValid_q <= 1'b0;
         changeAmt_q   <= '0;
         coinRej_q     <= 1'b0;
         errValid_q    <= 1'b0;
         errCode_q     <= ERR_NONE;
         for (int i = 0; i < NUM_PROD; i++) begin
            price_q[i] <= '0;
            stock_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         credit_q      <= credit_d;
         vendValid_q   <= vendValid_d;
         vendIdx_q     <= vendIdx_d;
         changeValid_q <= changeValid_d;
         changeAmt_q   <= changeAmt_d;
         coinRej_q     <= coinRej_d;
         errValid_q    <= errValid_d;
         errCode_q     <= errCode_d;
         for (int i = 0; i < NUM_PROD; i++) begin
            price_q[i] <= price_d[i];
            stock_q[i] <= stock_d[i];
         end
      end
   end

   assign ready        = (state_q == ACTIVE);
   assign credit       = credit_q;
   assign vend_valid   = vendValid_q;
   assign vend_idx     = vendIdx_q;
   assign change_valid = changeValid_q;
   assign change_amt   = changeAmt_q;
   assign coin_rej     = coinRej_q;
   assign err_valid    = errValid_q;
   assign err_code     = errCode_q;

endmodule

// File: tb/tb_vending_multi.sv
// Directed table-driven bench for vending_multi with default parameters,
// plus a hand-written stock saturation / depletion sequence.
module tb_vending_multi;

   localparam int NUM_PROD = 4;
   localparam int PRICE_W  = 8;
   localparam int CREDIT_W = 10;
   localparam int STOCK_W  = 4;
   localparam int SEL_W    = 2;

   logic                clk;
   logic                rst;
   logic                price_valid;
   logic [PRICE_W-1:0]  price_in;
   logic                restock_valid;
   logic [SEL_W-1:0]    restock_idx;
   logic [STOCK_W-1:0]  restock_qty;
   logic                coin_valid;
   logic [PRICE_W-1:0]  coin_in;
   logic                sel_valid;
   logic [SEL_W-1:0]    sel_idx;
   logic                refund;
   logic                ready;
   logic [CREDIT_W-1:0] credit;
   logic                vend_valid;
   logic [SEL_W-1:0]    vend_idx;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                coin_rej;
   logic                err_valid;
   logic [1:0]          err_code;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit rst;
      bit pv;
      int pin;
      bit rv;
      int ridx;
      int rqty;
      bit cv;
      int coin;
      bit sv;
      int sidx;
      bit rf;
      bit eRdy;
      int eCred;
      bit eVv;
      int eVidx;
      bit eChv;
      int eCamt;
      bit eRej;
      bit eEv;
      int eCode;
   } vec_t;

   vec_t vecs[$];

   vending_multi #(
      .NUM_PROD (NUM_PROD),
      .PRICE_W  (PRICE_W),
      .CREDIT_W (CREDIT_W),
      .STOCK_W  (STOCK_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .price_valid   (price_valid),
      .price_in      (price_in),
      .restock_valid (restock_valid),
      .restock_idx   (restock_idx),
      .restock_qty   (restock_qty),
      .coin_valid    (coin_valid),
      .coin_in       (coin_in),
      .sel_valid     (sel_valid),
      .sel_idx       (sel_idx),
      .refund        (refund),
      .ready         (ready),
      .credit        (credit),
      .vend_valid    (vend_valid),
      .vend_idx      (vend_idx),
      .change_valid  (change_valid),
      .change_amt    (change_amt),
      .coin_rej      (coin_rej),
      .err_valid     (err_valid),
      .err_code      (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs: rst pv pin rv ridx rqty cv coin sv sidx rf
   // Expected after the edge: rdy cred vv vidx chv camt rej ev code
   function automatic vec_t mk(input bit rst_, input bit pv, input int pin,
                               input bit rv, input int ridx, input int rqty,
                               input bit cv, input int coin, input bit sv,
                               input int sidx, input bit rf,
                               input bit rdy, input int cred, input bit vv,
                               input int vidx, input bit chv, input int camt,
                               input bit rej, input bit ev, input int code);
      vec_t v;
      v.rst = rst_; v.pv = pv; v.pin = pin; v.rv = rv; v.ridx = ridx;
      v.rqty = rqty; v.cv = cv; v.coin = coin; v.sv = sv; v.sidx = sidx;
      v.rf = rf; v.eRdy = rdy; v.eCred = cred; v.eVv = vv; v.eVidx = vidx;
      v.eChv = chv; v.eCamt = camt; v.eRej = rej; v.eEv = ev; v.eCode = code;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL step%0d %s: got %0d expected %0d", idx, name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst           = v.rst;
      price_valid   = v.pv;
      price_in      = PRICE_W'(v.pin);
      restock_valid = v.rv;
      restock_idx   = SEL_W'(v.ridx);
      restock_qty   = STOCK_W'(v.rqty);
      coin_valid    = v.cv;
      coin_in       = PRICE_W'(v.coin);
      sel_valid     = v.sv;
      sel_idx       = SEL_W'(v.sidx);
      refund        = v.rf;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      check("ready", idx, int'(ready), int'(v.eRdy));
      check("credit", idx, int'(credit), v.eCred);
      check("vend_valid", idx, int'(vend_valid), int'(v.eVv));
      if (v.eVv) check("vend_idx", idx, int'(vend_idx), v.eVidx);
      check("change_valid", idx, int'(change_valid), int'(v.eChv));
      check("change_amt", idx, int'(change_amt), v.eCamt);
      check("coin_rej", idx, int'(coin_rej), int'(v.eRej));
      check("err_valid", idx, int'(err_valid), int'(v.eEv));
      if (v.eEv) check("err_code", idx, int'(err_code), v.eCode);
   endtask

   initial begin
      vec_t v;

      // reset and price load 10,20,30,40
      vecs.push_back(mk(1,0,0, 0,0,0, 0,0, 0,0,0,   0,0,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,1,10,0,0,0, 0,0, 0,0,0,   0,0,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,1,20,0,0,0, 0,0, 0,0,0,   0,0,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,1,30,0,0,0, 0,0, 0,0,0,   0,0,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,1,40,0,0,0, 0,0, 0,0,0,   1,0,   0,0, 0,0,    0, 0,0));
      for (int i = 0; i < NUM_PROD; i++)
         vecs.push_back(mk(0,0,0, 1,i,2, 0,0, 0,0,0, 1,0, 0,0, 0,0, 0, 0,0));
      // exact payment
      vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 0,0,0,  1,10,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 0,0,0,  1,20,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  1,1,0,  1,0,   1,1, 1,0,    0, 0,0));
      // coin with selection in the same cycle, funds error, refund
      vecs.push_back(mk(0,0,0, 0,0,0, 1,25, 0,0,0,  1,25,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 1,2,0,  1,0,   1,2, 1,5,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,15, 0,0,0,  1,15,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  1,3,0,  1,15,  0,0, 0,0,    0, 1,1));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  0,0,1,  1,0,   0,0, 1,15,   0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,5,  1,3,0,  1,5,   0,0, 0,0,    0, 1,1));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  0,0,1,  1,0,   0,0, 1,5,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  0,0,1,  1,0,   0,0, 1,0,    0, 0,0));
      // deplete product 0, sold out, restock, vend
      vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 1,0,0,  1,0,   1,0, 1,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 1,0,0,  1,0,   1,0, 1,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,50, 0,0,0,  1,50,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  1,0,0,  1,50,  0,0, 0,0,    0, 1,2));
      vecs.push_back(mk(0,0,0, 1,0,1, 0,0,  0,0,0,  1,50,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  1,0,0,  1,0,   1,0, 1,40,   0, 0,0));
      // sold-out check sees pre-restock stock
      vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 0,0,0,  1,10,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 1,0,1, 0,0,  1,0,0,  1,10,  0,0, 0,0,    0, 1,2));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  1,0,0,  1,0,   1,0, 1,0,    0, 0,0));
      // credit saturation at 1023
      for (int i = 1; i <= 4; i++)
         vecs.push_back(mk(0,0,0, 0,0,0, 1,255, 0,0,0, 1,255*i, 0,0, 0,0, 0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 0,0,0,  1,1020, 0,0, 0,0,   1, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,3,  0,0,0,  1,1023, 0,0, 0,0,   0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,1,  0,0,0,  1,1023, 0,0, 0,0,   1, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  0,0,1,  1,0,   0,0, 1,1023, 0, 0,0));
      // reset with pending credit and a refund request: no payout
      vecs.push_back(mk(0,0,0, 0,0,0, 1,35, 0,0,0,  1,35,  0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(1,0,0, 0,0,0, 0,0,  0,0,1,  0,0,   0,0, 0,0,    0, 0,0));
      // reload 0,5,7,9 with coin/sel/refund/restock during LOAD
      vecs.push_back(mk(0,1,0, 0,0,0, 0,0,  0,0,0,  0,0,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,1,5, 1,1,3, 0,0,  0,0,1,  0,0,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,7,  1,1,0,  0,0,   0,0, 0,0,    1, 1,3));
      vecs.push_back(mk(0,1,7, 0,0,0, 0,0,  0,0,0,  0,0,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,1,9, 0,0,0, 0,0,  0,0,0,  1,0,   0,0, 0,0,    0, 0,0));
      // stock cleared by reset, LOAD restock ignored, zero price vends
      vecs.push_back(mk(0,0,0, 0,0,0, 1,8,  1,0,0,  1,8,   0,0, 0,0,    0, 1,2));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  1,1,0,  1,8,   0,0, 0,0,    0, 1,2));
      vecs.push_back(mk(0,0,0, 1,0,1, 0,0,  0,0,0,  1,8,   0,0, 0,0,    0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0,  1,0,0,  1,0,   1,0, 1,8,    0, 0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end

      // Stock saturates at 15 after two restocks of 15, then 15 vends succeed
      v = mk(0,0,0, 1,3,15, 0,0, 0,0,0, 1,0, 0,0, 0,0, 0, 0,0);
      applyStimulus(v);
      checkOutput(v, 1000);
      applyStimulus(v);
      checkOutput(v, 1001);
      for (int k = 0; k < 15; k++) begin
         v = mk(0,0,0, 0,0,0, 1,9, 1,3,0, 1,0, 1,3, 1,0, 0, 0,0);
         applyStimulus(v);
         checkOutput(v, 1002 + k);
      end
      v = mk(0,0,0, 0,0,0, 1,9, 1,3,0, 1,9, 0,0, 0,0, 0, 1,2);
      applyStimulus(v);
      checkOutput(v, 1017);
      v = mk(0,0,0, 0,0,0, 0,0, 0,0,1, 1,0, 0,0, 1,9, 0, 0,0);
      applyStimulus(v);
      checkOutput(v, 1018);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
